uart_receive: RTL

UART_RECEIVE -- requirements
Module: uart_receive

---
 rtl/uart_receive.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/uart_receive.sv
// 8N1 UART receiver: synchronises the serial line, samples each bit at its centre
// and reports good bytes or framing errors as single-cycle pulses.
module uart_receive #(
   parameter int unsigned BAUD_RATE        = 25_000_000,
   parameter int unsigned INPUT_CLOCK_FREQ = 100_000_000
) (
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic       rx_wire_in,
   output logic [7:0] data_byte_out,
   output logic       new_data_out,
   output logic       framing_error_out,
   output logic       busy_out
);

   localparam int unsigned PERIOD_CYCLES = INPUT_CLOCK_FREQ / BAUD_RATE;
   localparam int unsigned HALF_CYCLES   = PERIOD_CYCLES / 2;
   localparam int unsigned CNT_W         = $clog2(PERIOD_CYCLES) + 1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_d;
   logic             new_data_d;
   logic             ferr_d;
   logic [1:0]       sync_q;
   logic             rx_s;

   // Two-flop synchroniser; resets to the idle (high) line level
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rx_wire_in};
      end
   end

   assign rx_s = sync_q[1];

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q           <= IDLE;
         cnt_q             <= '0;
         idx_q             <= '0;
         shift_q           <= '0;
         data_byte_out     <= 8'h00;
         new_data_out      <= 1'b0;
         framing_error_out <= 1'b0;
         busy_out          <= 1'b0;
      end else begin
         state_q           <= state_d;
         cnt_q             <= cnt_d;
         idx_q             <= idx_d;
         shift_q           <= shift_d;
         data_byte_out     <= data_d;
         new_data_out      <= new_data_d;
         framing_error_out <= ferr_d;
         busy_out          <= (state_d != IDLE);
      end
   end

   // Counter reaching zero marks a bit centre; the start bit is re-checked half a bit in
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      shift_d    = shift_q;
      data_d     = data_byte_out;
      new_data_d = 1'b0;
      ferr_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               cnt_d   = CNT_W'(HALF_CYCLES - 1);
            end
         end
         START: begin
            if (cnt_q == '0) begin
               if (!rx_s) begin
                  state_d = DATA;
                  cnt_d   = CNT_W'(PERIOD_CYCLES - 1);
                  idx_d   = 3'd0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt_q == '0) begin
               shift_d[idx_q] = rx_s;
               cnt_d          = CNT_W'(PERIOD_CYCLES - 1);
               if (idx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         STOP: begin
            if (cnt_q == '0) begin
               if (rx_s) begin
                  data_d     = shift_q;
                  new_data_d = 1'b1;
                  state_d    = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         BREAK: begin
            // A line held low stays here silently until it returns to idle
            if (rx_s) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
